// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline register slice.
// Load-size encodings and default datapath widths.
package mem_wb_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        LS_WORD = 2'b00,
        LS_HALF = 2'b01,
        LS_BYTE = 2'b10,
        LS_RSVD = 2'b11
    } load_size_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side inputs and WB-side outputs.
// master drives the stage inputs, slave is the stage itself.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
);

    logic              Stall;
    logic              Flush;
    logic              MemToReg_in;
    logic              RegWrite_in;
    logic [REG_AW-1:0] rDest_in;
    logic [DATA_W-1:0] ALUResult_in;
    logic [DATA_W-1:0] MemWord_in;
    logic [1:0]        LoadSize_in;
    logic              LoadSigned_in;

    logic [DATA_W-1:0] R_Data;
    logic [DATA_W-1:0] ALUResult;
    logic              MemToReg;
    logic              RegWrite;
    logic [REG_AW-1:0] rDest;
    logic              Valid;
    logic              MisalignErr;

    modport master (
        output Stall, Flush, MemToReg_in, RegWrite_in, rDest_in,
        output ALUResult_in, MemWord_in, LoadSize_in, LoadSigned_in,
        input  R_Data, ALUResult, MemToReg, RegWrite, rDest,
        input  Valid, MisalignErr
    );

    modport slave (
        input  Stall, Flush, MemToReg_in, RegWrite_in, rDest_in,
        input  ALUResult_in, MemWord_in, LoadSize_in, LoadSigned_in,
        output R_Data, ALUResult, MemToReg, RegWrite, rDest,
        output Valid, MisalignErr
    );

endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Big-endian lane extraction and sign/zero extension of a loaded word.
// Also flags accesses whose offset does not suit the load size.
module load_extend
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        offset_i,
    input  load_size_e        size_i,
    input  logic              signed_i,
    output logic [DATA_W-1:0] data_o,
    output logic              misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Offset 0 is the most significant lane.
    always_comb begin
        byte_sel = 8'h00;
        unique case (offset_i)
            2'd0: byte_sel = word_i[DATA_W-1  -: 8];
            2'd1: byte_sel = word_i[DATA_W-9  -: 8];
            2'd2: byte_sel = word_i[DATA_W-17 -: 8];
            2'd3: byte_sel = word_i[7:0];
        endcase
        half_sel = offset_i[1] ? word_i[15:0] : word_i[DATA_W-1 -: 16];
    end

    always_comb begin
        data_o       = '0;
        misaligned_o = 1'b0;
        unique case (size_i)
            LS_WORD: begin
                data_o       = word_i;
                misaligned_o = (offset_i != 2'd0);
            end
            LS_HALF: begin
                data_o       = {{(DATA_W-16){signed_i & half_sel[15]}}, half_sel};
                misaligned_o = offset_i[0];
            end
            LS_BYTE: begin
                data_o = {{(DATA_W-8){signed_i & byte_sel[7]}}, byte_sel};
            end
            LS_RSVD: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and misalign guard.
// Outputs derive only from registered state; one cycle latency.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input logic           Clock,
    input logic           Reset,
    mem_wb_stage_if.slave bus
);

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic [REG_AW-1:0] rdest_q, rdest_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] word_q, word_d;
    load_size_e        size_q, size_d;
    logic              signed_q, signed_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] ext_data;
    logic              misaligned;
    logic              mis_hit;

    load_extend #(.DATA_W(DATA_W)) u_ext (
        .word_i      (word_q),
        .offset_i    (alu_q[1:0]),
        .size_i      (size_q),
        .signed_i    (signed_q),
        .data_o      (ext_data),
        .misaligned_o(misaligned)
    );

    assign mis_hit = valid_q & memtoreg_q & misaligned;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        rdest_d    = rdest_q;
        alu_d      = alu_q;
        word_d     = word_q;
        size_d     = size_q;
        signed_d   = signed_q;
        // Sticky error tracks the currently held load, regardless of stall.
        err_d      = err_q | mis_hit;
        if (bus.Flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
        end else if (!bus.Stall) begin
            valid_d    = 1'b1;
            regwrite_d = bus.RegWrite_in;
            memtoreg_d = bus.MemToReg_in;
            rdest_d    = bus.rDest_in;
            alu_d      = bus.ALUResult_in;
            word_d     = bus.MemWord_in;
            size_d     = load_size_e'(bus.LoadSize_in);
            signed_d   = bus.LoadSigned_in;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rdest_q    <= '0;
            alu_q      <= '0;
            word_q     <= '0;
            size_q     <= LS_WORD;
            signed_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            rdest_q    <= rdest_d;
            alu_q      <= alu_d;
            word_q     <= word_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            err_q      <= err_d;
        end
    end

    assign bus.R_Data      = ext_data;
    assign bus.ALUResult   = alu_q;
    assign bus.MemToReg    = memtoreg_q;
    assign bus.RegWrite    = regwrite_q & valid_q & ~mis_hit;
    assign bus.rDest       = rdest_q;
    assign bus.Valid       = valid_q;
    assign bus.MisalignErr = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table, corner sequences, random vs model.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mem_wb_stage;

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    mem_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference state: what the stage should be holding.
    logic        m_valid, m_rw, m_m2r, m_sgn, m_err;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_word;
    logic [1:0]  m_size;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] alu;
        logic [1:0]  sz;
        logic        sgn;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] e_data;
        logic        e_rw;
    } vec_t;

    vec_t tbl [0:10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic is_mis(input logic [1:0] sz,
                                    input logic [31:0] alu);
        int off;
        off = int'(alu[1:0]);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd0) return off != 0;
        if (sz == 2'd1) return (off % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] w,
            input logic [1:0] sz, input logic sg, input logic [31:0] alu);
        int off;
        logic [31:0] v;
        off = int'(alu[1:0]);
        v = 32'h0;
        if (sz == 2'd0) begin
            v = w;
        end else if (sz == 2'd1) begin
            v = (off >= 2) ? (w & 32'hFFFF) : (w >> 16);
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else if (sz == 2'd2) begin
            v = (w >> (24 - 8 * off)) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_m2r = 0; m_sgn = 0; m_err = 0;
        m_rd = 0; m_alu = 0; m_word = 0; m_size = 0;
    endtask

    task automatic model_edge();
        if (m_valid && m_m2r && is_mis(m_size, m_alu)) m_err = 1;
        if (bus.Flush) begin
            m_valid = 0; m_rw = 0; m_m2r = 0;
        end else if (!bus.Stall) begin
            m_valid = 1;
            m_rw    = bus.RegWrite_in;
            m_m2r   = bus.MemToReg_in;
            m_rd    = bus.rDest_in;
            m_alu   = bus.ALUResult_in;
            m_word  = bus.MemWord_in;
            m_size  = bus.LoadSize_in;
            m_sgn   = bus.LoadSigned_in;
        end
    endtask

    task automatic check_all(input string tag);
        logic mis;
        logic erw;
        mis = m_m2r && is_mis(m_size, m_alu);
        erw = m_rw && m_valid && !mis;
        chk({tag, "_valid"}, 32'(bus.Valid), 32'(m_valid));
        chk({tag, "_regwrite"}, 32'(bus.RegWrite), 32'(erw));
        chk({tag, "_memtoreg"}, 32'(bus.MemToReg), 32'(m_m2r));
        chk({tag, "_misalign"}, 32'(bus.MisalignErr), 32'(m_err));
        if (m_valid) begin
            chk({tag, "_rdest"}, 32'(bus.rDest), 32'(m_rd));
            chk({tag, "_alu"}, bus.ALUResult, m_alu);
            if (m_m2r && !mis)
                chk({tag, "_rdata"}, bus.R_Data,
                    ref_data(m_word, m_size, m_sgn, m_alu));
        end
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] alu,
            input logic [1:0] sz, input logic sg, input logic m2r,
            input logic rw, input logic [4:0] rd, input logic st,
            input logic fl);
        bus.MemWord_in    = w;
        bus.ALUResult_in  = alu;
        bus.LoadSize_in   = sz;
        bus.LoadSigned_in = sg;
        bus.MemToReg_in   = m2r;
        bus.RegWrite_in   = rw;
        bus.rDest_in      = rd;
        bus.Stall         = st;
        bus.Flush         = fl;
    endtask

    task automatic drive_rand(input logic st, input logic fl);
        drive($urandom, $urandom, 2'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom), st, fl);
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge Clock);
        #1;
        check_all(tag);
    endtask

    // Called 1ns after an edge; reset pulses and releases before the next.
    task automatic reset_mid_cycle(input string tag);
        #2 Reset = 1'b1;
        model_reset();
        #1;
        chk({tag, "_valid"}, 32'(bus.Valid), 32'h0);
        chk({tag, "_regwrite"}, 32'(bus.RegWrite), 32'h0);
        chk({tag, "_memtoreg"}, 32'(bus.MemToReg), 32'h0);
        chk({tag, "_misalign"}, 32'(bus.MisalignErr), 32'h0);
        chk({tag, "_rdest"}, 32'(bus.rDest), 32'h0);
        chk({tag, "_alu"}, bus.ALUResult, 32'h0);
        chk({tag, "_rdata"}, bus.R_Data, 32'h0);
        #2 Reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'h8899AABB, 32'h100, 2'd0, 1'b0, 1'b1, 1'b1, 5'd5,  32'h8899AABB, 1'b1};
        tbl[1]  = '{32'h8899AABB, 32'h101, 2'd2, 1'b1, 1'b1, 1'b1, 5'd6,  32'hFFFFFF99, 1'b1};
        tbl[2]  = '{32'h8899AABB, 32'h101, 2'd2, 1'b0, 1'b1, 1'b1, 5'd7,  32'h00000099, 1'b1};
        tbl[3]  = '{32'h1234F00D, 32'h102, 2'd1, 1'b1, 1'b1, 1'b1, 5'd8,  32'hFFFFF00D, 1'b1};
        tbl[4]  = '{32'h1234F00D, 32'h100, 2'd1, 1'b1, 1'b1, 1'b1, 5'd9,  32'h00001234, 1'b1};
        tbl[5]  = '{32'h8899AABB, 32'h103, 2'd2, 1'b0, 1'b1, 1'b1, 5'd10, 32'h000000BB, 1'b1};
        tbl[6]  = '{32'h8899AABB, 32'h102, 2'd2, 1'b1, 1'b1, 1'b1, 5'd11, 32'hFFFFFFAA, 1'b1};
        tbl[7]  = '{32'h8899AABB, 32'h100, 2'd1, 1'b1, 1'b1, 1'b1, 5'd12, 32'hFFFF8899, 1'b1};
        tbl[8]  = '{32'h8899AABB, 32'h100, 2'd0, 1'b0, 1'b1, 1'b1, 5'd0,  32'h8899AABB, 1'b1};
        tbl[9]  = '{32'h8899AABB, 32'h103, 2'd0, 1'b0, 1'b0, 1'b1, 5'd13, 32'h00000000, 1'b1};
        tbl[10] = '{32'h8899AABB, 32'h100, 2'd0, 1'b0, 1'b1, 1'b0, 5'd14, 32'h8899AABB, 1'b0};

        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("rst_valid", 32'(bus.Valid), 32'h0);
        chk("rst_regwrite", 32'(bus.RegWrite), 32'h0);
        chk("rst_memtoreg", 32'(bus.MemToReg), 32'h0);
        chk("rst_misalign", 32'(bus.MisalignErr), 32'h0);
        chk("rst_rdest", 32'(bus.rDest), 32'h0);
        chk("rst_alu", bus.ALUResult, 32'h0);
        chk("rst_rdata", bus.R_Data, 32'h0);
        @(posedge Clock);
        #1 Reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].word, tbl[i].alu, tbl[i].sz, tbl[i].sgn,
                  tbl[i].m2r, tbl[i].rw, tbl[i].rd, 1'b0, 1'b0);
            cycle("tbl");
            if (tbl[i].m2r) chk("tbl_rdata_exp", bus.R_Data, tbl[i].e_data);
            chk("tbl_rw_exp", 32'(bus.RegWrite), 32'(tbl[i].e_rw));
            chk("tbl_valid_exp", 32'(bus.Valid), 32'h1);
            chk("tbl_rdest_exp", 32'(bus.rDest), 32'(tbl[i].rd));
            chk("tbl_alu_exp", bus.ALUResult, tbl[i].alu);
        end

        // Stall freezes outputs while inputs churn; Flush beats Stall.
        drive(32'h11223344, 32'h200, 2'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        cycle("stall_load");
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1, 1'b0);
            cycle("stall");
            chk("stall_rdata", bus.R_Data, 32'h11223344);
            chk("stall_rdest", 32'(bus.rDest), 32'd3);
            chk("stall_valid", 32'(bus.Valid), 32'h1);
            chk("stall_rw", 32'(bus.RegWrite), 32'h1);
        end
        drive_rand(1'b1, 1'b1);
        cycle("flush");
        chk("flush_valid", 32'(bus.Valid), 32'h0);
        chk("flush_rw", 32'(bus.RegWrite), 32'h0);

        // Asynchronous reset between edges, then a clean capture.
        drive(32'hCAFEBABE, 32'h300, 2'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        cycle("pre_rst");
        chk("pre_rst_valid", 32'(bus.Valid), 32'h1);
        chk("pre_rst_rw", 32'(bus.RegWrite), 32'h1);
        reset_mid_cycle("arst");
        drive(32'h0BADF00D, 32'h304, 2'd0, 1'b0, 1'b1, 1'b1, 5'd17, 1'b0, 1'b0);
        cycle("post_rst");
        chk("post_rst_rdata", bus.R_Data, 32'h0BADF00D);
        chk("post_rst_rw", 32'(bus.RegWrite), 32'h1);
        chk("post_rst_rdest", 32'(bus.rDest), 32'd17);

        // Misaligned half: write suppressed now, sticky error next edge.
        drive(32'h1234F00D, 32'h103, 2'd1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        cycle("mis_load");
        chk("mis_rw", 32'(bus.RegWrite), 32'h0);
        chk("mis_valid", 32'(bus.Valid), 32'h1);
        drive(32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle("mis_next");
        chk("mis_err_set", 32'(bus.MisalignErr), 32'h1);
        for (int i = 0; i < 10; i++) begin
            drive(32'($urandom), 32'h0, 2'd0, 1'b0, 1'b0, 1'($urandom),
                  5'($urandom), 1'($urandom), 1'b0);
            cycle("mis_hold");
        end
        chk("mis_err_sticky", 32'(bus.MisalignErr), 32'h1);
        reset_mid_cycle("mis_rst");

        for (int i = 0; i < 400; i++) begin
            drive_rand(($urandom % 5) == 0, ($urandom % 7) == 0);
            cycle("rnd");
            if (i % 97 == 96) reset_mid_cycle("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
